// File: rtl/alu_share_arb_if.sv
// Request/response channels between two requesters and the shared-ALU arbiter.
// The arbiter side uses the slave modport, requesters use master.
interface alu_share_arb_if #(
    parameter int W = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [3:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [3:0]   req1_op;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer letting two requesters time-share one combinational ALU.
// Optional illegal-opcode checking is enabled by defining ALU_SHARE_ARB_OPCHK_EN.
module alu_share_arb #(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_share_arb_if.slave bus,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_op,
    input  logic [W-1:0]  alu_c,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_opa;
    logic [W-1:0] r_opb;
    logic [3:0]   r_opc;
    logic [W-1:0] r_res;
    logic         r_owner;
    logic         r_last;
    logic         r_rsp0Valid;
    logic         r_rsp1Valid;
    logic         r_busy;

    logic         w_grant0;
    logic         w_grant1;
    logic         w_hs0;
    logic         w_hs1;
    logic         w_rspDone;

    // When both requesters are valid, the one not served last wins.
    assign w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last);
    assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last);

    assign bus.req0_ready = (r_state == S_IDLE) && w_grant0;
    assign bus.req1_ready = (r_state == S_IDLE) && w_grant1;
    assign w_hs0          = bus.req0_valid && bus.req0_ready;
    assign w_hs1          = bus.req1_valid && bus.req1_ready;
    assign w_rspDone      = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.rsp0_valid = r_rsp0Valid;
    assign bus.rsp1_valid = r_rsp1Valid;
    assign bus.rsp_data   = r_res;
    assign busy           = r_busy;

`ifdef ALU_SHARE_ARB_OPCHK_EN
    logic w_illegal;
    logic r_err;

    assign w_illegal   = (r_opc >= 4'd10);
    assign bus.rsp_err = r_err;

    // Illegal opcodes present a neutral ADDU 0+0 to the ALU while executing.
    always_comb begin
        alu_a  = r_opa;
        alu_b  = r_opb;
        alu_op = r_opc;
        if ((r_state == S_EXEC) && w_illegal) begin
            alu_a  = '0;
            alu_b  = '0;
            alu_op = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_err <= w_illegal;
        end
    end
`else
    assign bus.rsp_err = 1'b0;

    always_comb begin
        alu_a  = r_opa;
        alu_b  = r_opb;
        alu_op = r_opc;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_opa       <= '0;
            r_opb       <= '0;
            r_opc       <= 4'b0000;
            r_res       <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_rsp0Valid <= 1'b0;
            r_rsp1Valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs0) begin
                        r_opa   <= bus.req0_a;
                        r_opb   <= bus.req0_b;
                        r_opc   <= bus.req0_op;
                        r_owner <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end else if (w_hs1) begin
                        r_opa   <= bus.req1_a;
                        r_opb   <= bus.req1_b;
                        r_opc   <= bus.req1_op;
                        r_owner <= 1'b1;
                        r_last  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
`ifdef ALU_SHARE_ARB_OPCHK_EN
                    r_res <= w_illegal ? {W{1'b1}} : alu_c;
`else
                    r_res <= alu_c;
`endif
                    r_rsp0Valid <= !r_owner;
                    r_rsp1Valid <= r_owner;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (w_rspDone) begin
                        r_rsp0Valid <= 1'b0;
                        r_rsp1Valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed and randomized transactions with a bench-side ALU
// and a transaction-level reference model; honours ALU_SHARE_ARB_OPCHK_EN when defined.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [31:0] aluC;
    logic [3:0]  aluOp;
    logic        busy;
    int          total = 0;
    int          bad = 0;

    alu_share_arb_if #(.W(32)) bus ();

    alu_share_arb #(.W(32)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .alu_a  (aluA),
        .alu_b  (aluB),
        .alu_op (aluOp),
        .alu_c  (aluC),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return (a > b) ? 32'd1 : 32'd0;
            4'd9:    return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU sitting behind the arbiter.
    always_comb aluC = aluRef(aluA, aluB, aluOp);

    function automatic logic checkedIllegal(input logic [3:0] op);
`ifdef ALU_SHARE_ARB_OPCHK_EN
        return op >= 4'd10;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] expectedData(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        return checkedIllegal(op) ? 32'hFFFF_FFFF : aluRef(a, b, op);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int port, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    function automatic logic getReady(input int port);
        return (port == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic getRspValid(input int port);
        return (port == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    task automatic setRspReady(input int port, input logic v);
        if (port == 0) bus.rsp0_ready = v;
        else           bus.rsp1_ready = v;
    endtask

    // One complete transaction on a requester, with 'hold' cycles of response backpressure.
    task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input int hold);
        int          waited = 0;
        int          other = 1 - port;
        logic [31:0] expD = expectedData(a, b, op);
        logic        ill = checkedIllegal(op);
        @(negedge clk);
        setReq(port, 1'b1, a, b, op);
        #1;
        while (!getReady(port) && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("grantReady", {31'b0, getReady(port)}, 32'd1);
        if (!getReady(port)) begin
            setReq(port, 1'b0, 32'd0, 32'd0, 4'd0);
            return;
        end
        setRspReady(port, 1'b0);
        @(posedge clk);
        @(negedge clk);
        setReq(port, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("execBusy", {31'b0, busy}, 32'd1);
        checkOutput("execNoRsp", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        checkOutput("execAluA", aluA, ill ? 32'd0 : a);
        checkOutput("execAluB", aluB, ill ? 32'd0 : b);
        checkOutput("execAluOp", {28'b0, aluOp}, ill ? 32'd0 : {28'b0, op});
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            checkOutput("bpRspValid", {31'b0, getRspValid(port)}, 32'd1);
            checkOutput("bpRspData", bus.rsp_data, expD);
            setReq(other, 1'b1, 32'd1, 32'd1, 4'd0);
            #1;
            checkOutput("bpOtherReady", {31'b0, getReady(other)}, 32'd0);
            @(negedge clk);
        end
        setReq(other, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("rspValid", {31'b0, getRspValid(port)}, 32'd1);
        checkOutput("rspOtherValid", {31'b0, getRspValid(other)}, 32'd0);
        checkOutput("rspData", bus.rsp_data, expD);
        checkOutput("rspErr", {31'b0, bus.rsp_err}, {31'b0, ill});
        setRspReady(port, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("idleBusy", {31'b0, busy}, 32'd0);
        checkOutput("idleRspValid", {31'b0, getRspValid(port)}, 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          got;
        int          waited;
        logic        sawRsp;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;

        reset_n = 1'b0;
        setReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        setReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstRspValid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        checkOutput("rstAluA", aluA, 32'd0);
        checkOutput("rstAluB", aluB, 32'd0);
        checkOutput("rstAluOp", {28'b0, aluOp}, 32'd0);
        checkOutput("rstRspData", bus.rsp_data, 32'd0);
        checkOutput("rstRspErr", {31'b0, bus.rsp_err}, 32'd0);
        reset_n = 1'b1;

        applyStimulus(0, 32'd5, 32'd3, 4'b0001, 0);
        applyStimulus(0, 32'h8000_0000, 32'd1, 4'b1000, 0);
        applyStimulus(1, 32'h8000_0000, 32'd1, 4'b1001, 0);
        applyStimulus(0, 32'd7, 32'd9, 4'b1100, 0);
        applyStimulus(1, 32'h8000_0000, 32'd4, 4'b0111, 5);

        for (int n = 0; n < 16; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 4'($urandom_range(0, 11));
            applyStimulus(int'($urandom_range(0, 1)), ra, rb, rop, int'($urandom_range(0, 3)));
        end

        // Contention: both held valid, responses must alternate 0,1,0,1 after reset.
        doReset();
        @(negedge clk);
        setReq(0, 1'b1, 32'd1, 32'd1, 4'b0000);
        setReq(1, 1'b1, 32'hFFFF_FFFF, 32'd0, 4'b1001);
        got = 0;
        waited = 0;
        while (got < 4 && waited < 40) begin
            @(negedge clk);
            waited++;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                checkOutput("contOrder", {31'b0, bus.rsp1_valid}, 32'(got % 2));
                checkOutput("contData", bus.rsp_data, (got % 2 == 0) ? 32'd2 : 32'd0);
                got++;
            end
        end
        checkOutput("contCount", 32'(got), 32'd4);
        setReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        setReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        waited = 0;
        while (busy && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("contDrain", {31'b0, busy}, 32'd0);

        // Reset during EXEC drops the transaction silently.
        setReq(0, 1'b1, 32'd5, 32'd3, 4'b0000);
        #1;
        checkOutput("midReady", {31'b0, bus.req0_ready}, 32'd1);
        @(negedge clk);
        setReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        checkOutput("midExecBusy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
        checkOutput("midRstRsp", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        checkOutput("midRstAluA", aluA, 32'd0);
        checkOutput("midRstAluOp", {28'b0, aluOp}, 32'd0);
        checkOutput("midRstData", bus.rsp_data, 32'd0);
        reset_n = 1'b1;
        sawRsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sawRsp = sawRsp | bus.rsp0_valid | bus.rsp1_valid;
        end
        checkOutput("midNoRsp", {31'b0, sawRsp}, 32'd0);
        setReq(0, 1'b1, 32'd1, 32'd2, 4'b0000);
        setReq(1, 1'b1, 32'd3, 32'd4, 4'b0000);
        #1;
        checkOutput("postRstGrant0", {31'b0, bus.req0_ready}, 32'd1);
        checkOutput("postRstGrant1", {31'b0, bus.req1_ready}, 32'd0);
        setReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
        setReq(1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
